mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Shares the single tagged memory port between the instruction cache (demand fetch plus prefetch, already muxed into one request) and the data cache. Grants one requester per cycle, with data-cache priority bounded by a starvation limit. Returns the memory's acceptance tag only to the granted side, and records which side owns each outstanding tag so that returning data is steered to the right cache. Sits between both caches and the memory model; it drives the `d_request` input of the icache.

## Interface
- `STARVE_LIMIT`, default 4: maximum number of consecutive dcache grants while an icache request is waiting.
- `NUM_TAGS`, default 16: memory tag space. Tag 0 means "no response / no tag".
- `clock`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `Icache2mem_command`  in  2  BUS_NONE or BUS_LOAD
- `Icache2mem_addr`  in  `XLEN`  icache request address
- `Dcache2mem_command`  in  2  BUS_NONE, BUS_LOAD or BUS_STORE
- `Dcache2mem_addr`  in  `XLEN`  dcache request address
- `Dcache2mem_data`  in  64  store data
- `Imem2proc_response`  in  4  memory acceptance tag, same cycle as the command
- `Imem2proc_data`  in  64  returning data
- `Imem2proc_tag`  in  4  tag of the returning data
- `proc2Imem_command`  out  2  command to memory
- `proc2Imem_addr`  out  `XLEN`  address to memory
- `proc2Imem_data`  out  64  store data to memory
- `d_request`  out  1  dcache holds the port this cycle
- `mem2Icache_response`  out  4  acceptance tag for the icache, 0 unless the icache is granted
- `mem2Dcache_response`  out  4  acceptance tag for the dcache, 0 unless the dcache is granted
- `mem2Icache_tag`, `mem2Dcache_tag`  out  4  returning tag, steered by owner, 0 to the other side
- `mem2Icache_data`, `mem2Dcache_data`  out  64  copy of `Imem2proc_data`
- `outstanding_cnt`  out  5  number of valid owner-table entries (registered)

## Operation
- **Request detection:** a side requests when its command is not BUS_NONE.
- **Grant rule:**
  - Dcache wins by default.
  - The icache wins when the dcache is idle.
  - The icache also wins when `starve_cnt == STARVE_LIMIT` and both sides request.
- **Starve counter:** `starve_cnt` (3 bits, saturating at STARVE_LIMIT) counts consecutive dcache grants while the icache is requesting. It clears on any icache grant, and it clears in any cycle in which the icache is not requesting.
- **Memory port:** driven by the winner's command, address and data. With no winner it carries BUS_NONE and address/data 0.
- **Acceptance:** `d_request` = dcache granted. `Imem2proc_response` is forwarded only to the winner; the other side sees 0.
- **Owner table:** `NUM_TAGS` entries of {valid, owner}.
  - On a nonzero response to a LOAD, entry[response] is set to {1, winner} at the clock edge.
  - STORE acceptances are not recorded.
- **Data return:** when `Imem2proc_tag != 0` and the table entry is valid, the tag goes to the owner's tag output and the entry clears at the edge.
  - A tag whose entry is invalid is dropped: both tag outputs are 0.
- **Same tag allocated and retired in one cycle:** allocation wins, so the entry stays valid with the new owner.
- **Reset:** clears the table, `starve_cnt` and `outstanding_cnt`. Tags returning after reset are dropped.

## Timing
- Grant, response steering and tag steering are combinational, with zero-cycle latency. Acceptance is visible to the requester in the same cycle it drives its command.
- The owner table, `starve_cnt` and `outstanding_cnt` update on `posedge clock`.
- Returned data is routed using the table state from before the edge. Memory latency of at least 1 cycle guarantees a tag never returns in its allocation cycle.
- Reset values:
  - all response and tag outputs 0
  - `proc2Imem_command` = BUS_NONE
  - `d_request` = 0
  - `outstanding_cnt` = 0
- Because reset is synchronous, outputs are forced to these values during reset regardless of inputs.
- **Rejected request** (response 0): nothing is recorded. The requester re-presents its command; the arbiter holds no request state.
- `outstanding_cnt` is the next value of: previous count + allocation − retirement, where allocation and retirement of the same tag in one cycle nets 0. It never exceeds 15.

## Structure
- Bus command encodings (BUS_NONE, BUS_LOAD, BUS_STORE) come from the shared system-definitions package.
- Add `MEM_OWNER_I`/`MEM_OWNER_D` as an enum typedef in the same package.
- One sub-module, `mem_tag_table`, holds the valid/owner storage:
  - allocation port
  - lookup/retire port
  - count output
- Grant logic and the starvation counter live in the top module.

## Test plan
- **Dcache only:** dcache LOAD to 0x100, memory response 3 → `mem2Dcache_response` = 3, `d_request` = 1, icache response 0. Later tag 3 returns → `mem2Dcache_tag` = 3, `outstanding_cnt` 1 → 0.
- **Contention:** both sides LOAD every cycle, all accepted → dcache granted 4 cycles, icache on the 5th, pattern repeats. `starve_cnt` resets after the icache grant.
- **Store:** dcache STORE with data 0xDEADBEEF, response 5 → memory sees BUS_STORE and the data. Table is unchanged; a later tag 5 is dropped.
- **Interleaved returns:** icache allocated tag 2, dcache tag 7. Tags return 7 then 2 → each is steered to its owner only. Same-cycle alloc/retire of tag 2 keeps the entry valid.
- **Reset mid-flight:** 3 tags outstanding, reset asserted for 1 cycle, then tags return → all dropped, `outstanding_cnt` = 0.
- **Rejection:** icache LOAD with response 0 → nothing recorded, `mem2Icache_response` = 0. The retry next cycle with response 4 allocates tag 4 as icache.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared system definitions for the memory bus: bus command encodings,
// tag width and the owner enum used by the arbiter's tag table.
package mem_bus_arbiter_pkg;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_cmd_e;

  typedef enum logic {
    MEM_OWNER_I = 1'b0,
    MEM_OWNER_D = 1'b1
  } mem_owner_e;

endpackage

// File: rtl/mem_tag_table.sv
// Valid/owner record per outstanding memory tag. Allocation and lookup are
// independent ports; a lookup hit retires its entry at the next edge.
module mem_tag_table
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_TAGS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_tag,
  input  mem_owner_e       alloc_owner,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             lookup_hit,
  output mem_owner_e       lookup_owner,
  output logic [CNT_W-1:0] count
);

  logic [NUM_TAGS-1:0] valid_q, valid_d;
  mem_owner_e          owner_q [NUM_TAGS];
  mem_owner_e          owner_d [NUM_TAGS];
  logic [CNT_W-1:0]    count_q, count_d;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    lookup_hit   = 1'b0;
    lookup_owner = MEM_OWNER_I;
    if (lookup_tag != '0 && int'(lookup_tag) < NUM_TAGS) begin
      lookup_hit   = valid_q[lookup_tag];
      lookup_owner = owner_q[lookup_tag];
    end
  end

  // Retire before allocate so a tag reused in its own retirement cycle stays valid.
  always_comb begin
    valid_d = valid_q;
    owner_d = owner_q;
    if (lookup_hit) begin
      valid_d[lookup_tag] = 1'b0;
    end
    if (alloc_en && alloc_tag != '0 && int'(alloc_tag) < NUM_TAGS) begin
      valid_d[alloc_tag] = 1'b1;
      owner_d[alloc_tag] = alloc_owner;
    end
    count_d = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      count_d = count_d + CNT_W'(valid_d[i]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // NOTE: owner storage is deliberately not reset; it is only read when the
  // matching valid bit is set, so reset of the valid vector is sufficient.
  always_ff @(posedge clock) begin
    owner_q <= owner_d;
  end

  assign count = count_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the shared memory port between icache and dcache with bounded
// dcache priority, and steers returning tags to the cache that issued them.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int NUM_TAGS     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       Icache2mem_command,
  input  logic [XLEN-1:0]  Icache2mem_addr,
  input  logic [1:0]       Dcache2mem_command,
  input  logic [XLEN-1:0]  Dcache2mem_addr,
  input  logic [63:0]      Dcache2mem_data,
  input  logic [TAG_W-1:0] Imem2proc_response,
  input  logic [63:0]      Imem2proc_data,
  input  logic [TAG_W-1:0] Imem2proc_tag,
  output logic [1:0]       proc2Imem_command,
  output logic [XLEN-1:0]  proc2Imem_addr,
  output logic [63:0]      proc2Imem_data,
  output logic             d_request,
  output logic [TAG_W-1:0] mem2Icache_response,
  output logic [TAG_W-1:0] mem2Dcache_response,
  output logic [TAG_W-1:0] mem2Icache_tag,
  output logic [TAG_W-1:0] mem2Dcache_tag,
  output logic [63:0]      mem2Icache_data,
  output logic [63:0]      mem2Dcache_data,
  output logic [CNT_W-1:0] outstanding_cnt
);

  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  logic       i_req, d_req;
  logic       grant_i, grant_d;
  logic [2:0] starve_q, starve_d;

  logic       alloc_en;
  mem_owner_e alloc_owner;
  logic       ret_hit;
  mem_owner_e ret_owner;

  // Grants are suppressed during reset so the port and acceptances read idle.
  always_comb begin
    i_req   = Icache2mem_command != BUS_NONE;
    d_req   = Dcache2mem_command != BUS_NONE;
    grant_d = d_req && !(i_req && starve_q == STARVE_MAX);
    grant_i = i_req && !grant_d;
    if (reset) begin
      grant_d = 1'b0;
      grant_i = 1'b0;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!i_req || grant_i) begin
      starve_d = '0;
    end else if (grant_d && starve_q < STARVE_MAX) begin
      starve_d = starve_q + 3'd1;
    end
  end

  always_comb begin
    proc2Imem_command   = BUS_NONE;
    proc2Imem_addr      = '0;
    proc2Imem_data      = '0;
    mem2Icache_response = '0;
    mem2Dcache_response = '0;
    if (grant_d) begin
      proc2Imem_command   = Dcache2mem_command;
      proc2Imem_addr      = Dcache2mem_addr;
      proc2Imem_data      = Dcache2mem_data;
      mem2Dcache_response = Imem2proc_response;
    end else if (grant_i) begin
      proc2Imem_command   = Icache2mem_command;
      proc2Imem_addr      = Icache2mem_addr;
      mem2Icache_response = Imem2proc_response;
    end
    d_request = grant_d;
  end

  // Only accepted loads produce a later data return, so only they are recorded.
  always_comb begin
    alloc_en    = (grant_i || grant_d) && Imem2proc_response != '0
                  && proc2Imem_command == BUS_LOAD;
    alloc_owner = grant_d ? MEM_OWNER_D : MEM_OWNER_I;
  end

  always_comb begin
    mem2Icache_tag = '0;
    mem2Dcache_tag = '0;
    if (ret_hit && !reset) begin
      if (ret_owner == MEM_OWNER_D) begin
        mem2Dcache_tag = Imem2proc_tag;
      end else begin
        mem2Icache_tag = Imem2proc_tag;
      end
    end
  end

  assign mem2Icache_data = Imem2proc_data;
  assign mem2Dcache_data = Imem2proc_data;

  mem_tag_table #(
    .NUM_TAGS (NUM_TAGS)
  ) u_tag_table (
    .clock        (clock),
    .reset        (reset),
    .alloc_en     (alloc_en),
    .alloc_tag    (Imem2proc_response),
    .alloc_owner  (alloc_owner),
    .lookup_tag   (Imem2proc_tag),
    .lookup_hit   (ret_hit),
    .lookup_owner (ret_owner),
    .count        (outstanding_cnt)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule
